sdp_ram_rd_streamer: RTL and testbench
======================================

// Module: sdp_ram_rd_streamer
// PURPOSE
//  Read-side master for the simple dual-port RAM: takes a burst command (start address, length), drives the RAM
//  read port (reb/addrb) and converts its fixed read latency into a valid/ready stream with last-beat marking.
//  Sits between the RAM read port and any stream consumer (DMA, UART TX, display fetch). Full throughput with no loss under backpressure.
// PARAMETERS
//  DATA_W      32   RAM word / stream data width
//  RAM_DEPTH   256  RAM entries; address wraps modulo RAM_DEPTH (need not be a power of two)
//  DEPTH_W     8    address width, = clog2(RAM_DEPTH); must match the RAM instance
//  LEN_W       9    burst length width, DEPTH_W+1 (a full-RAM burst is legal)
//  RD_LATENCY  2    RAM reb->doutb latency in cycles: 1 (LOW_LATENCY RAM) or 2 (NORMAL RAM)
//  BUF_DEPTH   4    output skid FIFO entries, power of two, >= RD_LATENCY+1 (full rate requires this)
// PORTS
//  clk        in   1        single clock; RAM shares it
//  rst_n      in   1        asynchronous, active-low reset
//  cmd_valid  in   1        burst command valid
//  cmd_ready  out  1        command accepted when cmd_valid&cmd_ready
//  cmd_addr   in   DEPTH_W  burst start address
//  cmd_len    in   LEN_W    burst length in words; 0 = null command
//  ram_reb    out  1        to RAM reb
//  ram_addrb  out  DEPTH_W  to RAM addrb
//  ram_doutb  in   DATA_W   from RAM doutb
//  m_valid    out  1        stream beat valid
//  m_ready    in   1        stream beat accepted when m_valid&m_ready
//  m_data     out  DATA_W   stream data
//  m_last     out  1        final beat of the burst
//  busy       out  1        high from command accept until the last beat is handed off
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, FIFO empty, in-flight tags cleared; ram_reb=0, ram_addrb=0, m_valid=0,
//    m_last=0, m_data=0, busy=0. cmd_ready=1 once rst_n deasserts. Mid-burst reset drops the burst; stale doutb ignored.
//  - FSM IDLE/ISSUE/DRAIN. cmd_ready=1 only in IDLE. IDLE + accept, len!=0: latch addr, remaining=len, busy=1 -> ISSUE.
//    IDLE + accept, len==0: consumed, no RAM access, no beat, stay IDLE.
//  - ISSUE: ram_reb = (remaining!=0) && (inflight+fifo_count < BUF_DEPTH); ram_addrb = current addr (registered).
//    Each issue: addr = (addr==RAM_DEPTH-1) ? 0 : addr+1; remaining--. Issue of last word -> DRAIN.
//  - In-flight tracking: RD_LATENCY-deep shift register of {valid,last} tags; a tag emerging with valid pushes
//    ram_doutb (and last) into the FIFO the same edge. inflight = number of valid tags (0..RD_LATENCY).
//  - Credit rule guarantees FIFO never overflows; push into full FIFO is a design error (assert in sim).
//  - Latency: cmd accepted in cycle 0 -> first ram_reb in cycle 1 -> m_valid in cycle 2+RD_LATENCY (cycle 4 default).
//  - Throughput: with m_ready held 1, one beat per cycle, no bubbles between beats of a burst.
//  - Stream: m_valid/m_data/m_last stable while m_valid&!m_ready; m_valid never drops without handshake.
//  - Simultaneous FIFO push and pop allowed every cycle; count unchanged.
//  - DRAIN -> IDLE when inflight==0, FIFO empty; busy falls the cycle after the m_last handshake. Next cmd accepted then.
//  - Wrap: burst crossing RAM_DEPTH-1 continues at address 0; len==RAM_DEPTH reads every entry once.
//  - No read/write hazard checking: a word written at the same address in the issue cycle returns old data.
// TESTING
//  1 Reset: rst_n=0 mid-burst -> all outputs 0 immediately (async); after release cmd_ready=1, no stray beats.
//  2 Basic: RAM[i]=i, cmd addr=0x10 len=8, m_ready=1 -> beats 0x10..0x17, m_valid first at cycle 4, m_last on 0x17 only.
//  3 Wrap: cmd addr=0xFE len=4 -> ram_addrb 0xFE,0xFF,0x00,0x01; data in same order, m_last on 4th.
//  4 Backpressure: len=16, m_ready random 30% -> all 16 words in order, none duplicated/lost, ram_reb stalls when credit 0.
//  5 Null/back-to-back: len=0 then len=1 -> first produces no beat; second yields one beat with m_last=1; busy pulses only for second.
//  6 RD_LATENCY=1 build: len=8, m_ready=1 -> m_valid first at cycle 3, 8 consecutive beats.

Source files
------------

// File: rtl/sdp_ram_rd_streamer.sv
// Burst read master for the simple dual-port RAM: issues reb/addrb under a credit limit and
// turns the fixed RAM read latency into a valid/ready stream with last-beat marking.
module sdp_ram_rd_streamer #(
  parameter int DATA_W     = 32,
  parameter int RAM_DEPTH  = 256,
  parameter int DEPTH_W    = 8,
  parameter int LEN_W      = 9,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DEPTH_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic               ram_reb,
  output logic [DEPTH_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0]  ram_doutb,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic               busy
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [DEPTH_W-1:0]    addr;
  logic [LEN_W-1:0]      remaining;
  logic                  reb_last;
  logic [RD_LATENCY-1:0] tag_v;
  logic [RD_LATENCY-1:0] tag_l;
  logic [DATA_W-1:0]     buf_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  buf_last;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;
  logic                  credit;
  logic [OCC_W-1:0]      occ;

  function automatic logic [DEPTH_W-1:0] next_addr(input logic [DEPTH_W-1:0] a);
    return (a == DEPTH_W'(RAM_DEPTH - 1)) ? '0 : a + DEPTH_W'(1);
  endfunction

  assign cmd_ready = (state == IDLE);
  assign m_valid   = (count != '0);
  assign m_data    = buf_data[rd_ptr];
  assign m_last    = buf_last[rd_ptr];
  assign push      = tag_v[RD_LATENCY-1];
  assign pop       = m_valid && m_ready;

  // Words committed after this edge: FIFO + tags + the read on the port now, minus this pop.
  always_comb begin
    occ = OCC_W'(count) + OCC_W'(ram_reb);
    for (int i = 0; i < RD_LATENCY; i++) occ = occ + OCC_W'(tag_v[i]);
    occ    = occ - OCC_W'(pop);
    credit = (occ < OCC_W'(BUF_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      reb_last  <= 1'b0;
      ram_reb   <= 1'b0;
      ram_addrb <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ram_reb  <= 1'b0;
          reb_last <= 1'b0;
          if (cmd_valid && cmd_len != '0) begin
            ram_reb   <= 1'b1;
            ram_addrb <= cmd_addr;
            addr      <= next_addr(cmd_addr);
            remaining <= cmd_len - LEN_W'(1);
            reb_last  <= (cmd_len == LEN_W'(1));
            busy      <= 1'b1;
            state     <= (cmd_len == LEN_W'(1)) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (credit && remaining != '0) begin
            ram_reb   <= 1'b1;
            ram_addrb <= addr;
            addr      <= next_addr(addr);
            remaining <= remaining - LEN_W'(1);
            reb_last  <= (remaining == LEN_W'(1));
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end else begin
            ram_reb  <= 1'b0;
            reb_last <= 1'b0;
          end
        end
        DRAIN: begin
          ram_reb  <= 1'b0;
          reb_last <= 1'b0;
          if (pop && m_last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v    <= '0;
      tag_l    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      buf_last <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_data[i] <= '0;
    end else begin
      tag_v[0] <= ram_reb;
      tag_l[0] <= reb_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
      if (push) begin
        buf_data[wr_ptr] <= ram_doutb;
        buf_last[wr_ptr] <= tag_l[RD_LATENCY-1];
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CNT_W'(BUF_DEPTH)));

endmodule

// File: tb/tb_sdp_ram_rd_streamer.sv
// Directed bench for sdp_ram_rd_streamer: latency-2 and latency-1 builds, each behind a RAM model;
// expected beats are queued at command time and checked as the stream hands them off.
module tb_sdp_ram_rd_streamer;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int LW = 9;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cv0, crdy0, reb0, mv0, rdy0, ml0, busy0;
  logic [AW-1:0] ca0, addrb0;
  logic [LW-1:0] cl0;
  logic [DW-1:0] dout0, p0, md0;
  logic          cv1, crdy1, reb1, mv1, rdy1, ml1, busy1;
  logic [AW-1:0] ca1, addrb1;
  logic [LW-1:0] cl1;
  logic [DW-1:0] dout1, md1;

  int tests = 0;
  int fails = 0;
  beat_t q0[$];
  beat_t q1[$];
  logic [AW-1:0] log0[$];

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {16'hC0DE, 8'h00, a};
  endfunction

  // RAM models: NORMAL (2-cycle) for u0, LOW_LATENCY (1-cycle) for u1
  always @(posedge clk) begin
    if (reb0) p0 <= word(addrb0);
    dout0 <= p0;
  end
  always @(posedge clk) if (reb1) dout1 <= word(addrb1);

  sdp_ram_rd_streamer u0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv0), .cmd_ready(crdy0), .cmd_addr(ca0), .cmd_len(cl0),
    .ram_reb(reb0), .ram_addrb(addrb0), .ram_doutb(dout0), .m_valid(mv0), .m_ready(rdy0),
    .m_data(md0), .m_last(ml0), .busy(busy0));

  sdp_ram_rd_streamer #(.RD_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(crdy1), .cmd_addr(ca1), .cmd_len(cl1),
    .ram_reb(reb1), .ram_addrb(addrb1), .ram_doutb(dout1), .m_valid(mv1), .m_ready(rdy1),
    .m_data(md1), .m_last(ml1), .busy(busy1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && reb0) log0.push_back(addrb0);
    if (rst_n && mv0 && rdy0) begin
      chk("beat0_expected", 64'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("beat0_data", 64'(md0), 64'(e.d));
        chk("beat0_last", 64'(ml0), 64'(e.l));
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && mv1 && rdy1) begin
      chk("beat1_expected", 64'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("beat1_data", 64'(md1), 64'(e.d));
        chk("beat1_last", 64'(ml1), 64'(e.l));
      end
    end
  end

  // Returns #1 after the accepting edge, i.e. in cycle 1 of the command.
  task automatic send(input bit which, input logic [AW-1:0] a, input logic [LW-1:0] n);
    int g = 0;
    int nn = int'(n);
    beat_t b;
    if (!which) begin
      cv0 = 1'b1; ca0 = a; cl0 = n;
      while (!crdy0 && g < 200) begin @(posedge clk); #1; g++; end
      chk("cmd0_ready_wait", 64'(crdy0), 1);
      @(posedge clk); #1;
      cv0 = 1'b0;
    end else begin
      cv1 = 1'b1; ca1 = a; cl1 = n;
      while (!crdy1 && g < 200) begin @(posedge clk); #1; g++; end
      chk("cmd1_ready_wait", 64'(crdy1), 1);
      @(posedge clk); #1;
      cv1 = 1'b0;
    end
    for (int i = 0; i < nn; i++) begin
      b.d = word(AW'(32'(a) + i));
      b.l = (i == nn - 1);
      if (!which) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic wait_idle(input bit which, input int max, input bit rand_rdy);
    int k = 0;
    while ((which ? busy1 : busy0) && k < max) begin
      if (rand_rdy) rdy0 = ($urandom_range(0, 99) >= 30);
      @(posedge clk); #1;
      k++;
    end
    rdy0 = 1'b1;
    chk(which ? "busy1_timeout" : "busy0_timeout", 64'(which ? busy1 : busy0), 0);
  endtask

  initial begin
    int cyc;
    logic [AW-1:0] exp_a [4];
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    cv0 = 0; ca0 = '0; cl0 = '0; rdy0 = 1;
    cv1 = 0; ca1 = '0; cl1 = '0; rdy1 = 1;

    // Power-on reset
    #12;
    chk("rst_reb", 64'(reb0), 0);
    chk("rst_addrb", 64'(addrb0), 0);
    chk("rst_m_valid", 64'(mv0), 0);
    chk("rst_m_data", 64'(md0), 0);
    chk("rst_busy", 64'(busy0), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", 64'(crdy0), 1);

    // Reset in the middle of a backpressured burst
    rdy0 = 1'b0;
    send(0, 8'h50, 9'd8);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk); rst_n = 1'b0; #1;
    chk("midrst_reb", 64'(reb0), 0);
    chk("midrst_addrb", 64'(addrb0), 0);
    chk("midrst_m_valid", 64'(mv0), 0);
    chk("midrst_m_last", 64'(ml0), 0);
    chk("midrst_m_data", 64'(md0), 0);
    chk("midrst_busy", 64'(busy0), 0);
    q0.delete();
    #20;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cmd_ready", 64'(crdy0), 1);
    rdy0 = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("midrst_no_stray", 64'(mv0), 0);

    // Basic burst: latency and throughput
    send(0, 8'h10, 9'd8);
    chk("basic_reb_cycle1", 64'(reb0), 1);
    chk("basic_addrb_cycle1", 64'(addrb0), 64'h10);
    cyc = 1;
    while (!mv0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("basic_first_valid_cycle", 64'(cyc), 4);
    for (int i = 0; i < 8; i++) begin
      chk("basic_no_bubble", 64'(mv0), 1);
      @(posedge clk); #1;
    end
    chk("basic_valid_after", 64'(mv0), 0);
    chk("basic_busy_after", 64'(busy0), 0);
    wait_idle(0, 50, 0);
    chk("basic_queue_empty", 64'(q0.size()), 0);

    // Address wrap
    log0.delete();
    send(0, 8'hFE, 9'd4);
    wait_idle(0, 50, 0);
    chk("wrap_issue_count", 64'(log0.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < log0.size()) chk("wrap_addrb", 64'(log0[i]), 64'(exp_a[i]));
    chk("wrap_queue_empty", 64'(q0.size()), 0);

    // Backpressure: full stall, then random ready
    log0.delete();
    rdy0 = 1'b0;
    send(0, 8'h40, 9'd16);
    repeat (12) begin @(posedge clk); #1; end
    chk("bp_reb_stalled", 64'(reb0), 0);
    chk("bp_issued_to_credit", 64'(log0.size()), 4);
    chk("bp_valid_held", 64'(mv0), 1);
    chk("bp_data_held", 64'(md0), 64'(word(8'h40)));
    chk("bp_last_held", 64'(ml0), 0);
    wait_idle(0, 1000, 1);
    chk("bp_queue_empty", 64'(q0.size()), 0);
    chk("bp_issue_total", 64'(log0.size()), 16);

    // Null command then single-beat command back to back
    send(0, 8'h20, 9'd0);
    chk("null_busy", 64'(busy0), 0);
    chk("null_cmd_ready", 64'(crdy0), 1);
    chk("null_no_reb", 64'(reb0), 0);
    send(0, 8'h33, 9'd1);
    chk("single_busy", 64'(busy0), 1);
    chk("single_reb", 64'(reb0), 1);
    wait_idle(0, 50, 0);
    chk("single_queue_empty", 64'(q0.size()), 0);

    // Low-latency RAM build
    send(1, 8'h80, 9'd8);
    chk("ll_reb_cycle1", 64'(reb1), 1);
    cyc = 1;
    while (!mv1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("ll_first_valid_cycle", 64'(cyc), 3);
    for (int i = 0; i < 8; i++) begin
      chk("ll_no_bubble", 64'(mv1), 1);
      @(posedge clk); #1;
    end
    chk("ll_valid_after", 64'(mv1), 0);
    wait_idle(1, 50, 0);
    chk("ll_queue_empty", 64'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
